multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001: clk  input  1  single clock; all state changes on rising edge SHALL use clk.
REQ-002: reset  input  1  asynchronous, active-high; SHALL force the FSM to FETCH immediately, independent of clk.
REQ-003: op  input  6  opcode field of the instruction register.
REQ-004: zero  input  1  ALU zero flag.
REQ-005: memready  input  1  memory handshake; 1 = access completes this cycle.
REQ-006: Memory path outputs, 1 bit each: iord (address select, 1 = ALUOut), irwrite, memwrite.
REQ-007: PC path outputs: pcen (1), pcsrc (2).
REQ-008: ALU operand outputs: alusrca (1), alusrcb (2), aluop (2), with aluop 00 = add, 01 = sub, 10 = funct-decoded.
REQ-009: Register file outputs, 1 bit each: regdst, memtoreg, regwrite.
REQ-010: state  output  4  current state encoding, for debug.
REQ-011: done  output  1  pulses in the final cycle of each completed instruction.
REQ-012: illegal  output  1  pulses in DECODE for an unsupported opcode.

Function
REQ-013: The FSM SHALL use these 4-bit encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014: Encodings 12-15 SHALL transition to FETCH and drive all control outputs 0.
REQ-015: Supported opcodes SHALL be RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-016: Transitions SHALL be:
  - FETCH -> DECODE if memready, else stay.
  - DECODE -> MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J), FETCH (any other op).
  - MEMADR -> MEMRD (LW), MEMWR (SW).
  - MEMRD -> MEMWB if memready, else stay.
  - MEMWR -> FETCH if memready, else stay.
  - MEMWB, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
REQ-017: Any control output not listed for the current state SHALL be 0.
REQ-018: FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, and irwrite=pcwrite=memready.
REQ-019: DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00.
REQ-020: MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00.
REQ-021: MEMRD SHALL drive iord=1.
REQ-022: MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1.
REQ-023: MEMWR SHALL drive iord=1 and memwrite=1, held every cycle until memready.
REQ-024: EXECUTE SHALL drive alusrca=1, alusrcb=00, aluop=10.
REQ-025: ALUWB SHALL drive regdst=1, memtoreg=0, regwrite=1.
REQ-026: ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-027: BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, internal branch=1.
REQ-028: JUMP SHALL drive pcsrc=10, internal pcwrite=1.
REQ-029: pcen SHALL equal pcwrite OR (branch AND zero), combinationally in the current cycle.
REQ-030: done SHALL be 1 in MEMWB, ALUWB, ADDIWB, BRANCH and JUMP, and in MEMWR only in the cycle memready=1.
REQ-031: illegal SHALL be 1 only in DECODE with an unsupported op; done SHALL stay 0 for that instruction.
REQ-032: All control outputs SHALL decode combinationally from state (and memready/zero where stated); only state is registered.
REQ-033: memready SHALL be ignored in every state except FETCH, MEMRD and MEMWR.

Reset
REQ-034: While reset=1, state SHALL be FETCH, and irwrite, pcen, memwrite, regwrite, done and illegal SHALL be 0 regardless of memready.
REQ-035: Reset asserted in any state, including mid memory wait, SHALL abort the instruction with no further regwrite or memwrite.
REQ-036: After reset deasserts, the first clock edge SHALL evaluate the FETCH transition normally.

Verification
REQ-037: LW, memready=1 throughout -> states 0,1,2,3,4 over 5 cycles; regwrite=memtoreg=done=1 only in cycle 5; back to FETCH.
REQ-038: SW, memready=0 for 2 cycles in MEMWR then 1 -> memwrite=1 for 3 consecutive cycles; done=1 only on the third.
REQ-039: BEQ with zero=1 -> pcen=1, pcsrc=01 in BRANCH.
REQ-040: BEQ with zero=0 -> pcen=0 in BRANCH; both cases take 3 cycles total.
REQ-041: op=111111 -> illegal=1 for one cycle in DECODE, no regwrite/memwrite, FETCH next.
REQ-042: FETCH with memready=0 for 4 cycles -> state holds 0, pcen=irwrite=0.
REQ-043: Reset pulsed mid-MEMRD -> state=0 asynchronously; regwrite never asserts for that LW.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for a multicycle MIPS-style datapath. One instruction is
// fetched, decoded and executed over several cycles. Only the state is
// registered. Every control output is decoded combinationally from the state,
// and from memready/zero in the few places where they matter.
//
// Handshake: memready is a level-sampled completion flag. When memready is 1
// in FETCH, MEMRD or MEMWR, the access in progress completes in that cycle and
// the FSM advances on the next rising edge. With memready 0 the FSM holds and
// drives the same access again. Every other state ignores memready.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset; forces FETCH immediately
//   op[5:0]    in   opcode field of the instruction register
//   zero       in   ALU zero flag, used by BEQ
//   memready   in   memory access completes this cycle
//   iord       out  memory address select (1 = ALUOut)
//   irwrite    out  instruction register write
//   memwrite   out  memory write strobe
//   pcen       out  PC enable = pcwrite | (branch & zero)
//   pcsrc[1:0] out  PC source select
//   alusrca    out  ALU A select
//   alusrcb    out  ALU B select
//   aluop[1:0] out  00 add, 01 sub, 10 funct-decoded
//   regdst     out  register file destination select
//   memtoreg   out  register file write-data select
//   regwrite   out  register file write enable
//   state[3:0] out  current state encoding (debug)
//   done       out  final cycle of a completed instruction
//   illegal    out  DECODE saw an unsupported opcode
// ----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] state,
    output logic       done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // Raw strobes before the reset gate.
    logic pcwrite;
    logic branch;
    logic irwrite_c;
    logic memwrite_c;
    logic regwrite_c;
    logic done_c;
    logic illegal_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_c = 1'b0;
        done_c     = 1'b0;
        illegal_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 and the IR load commit only in the cycle the fetch completes.
                alusrcb   = 2'b01;
                irwrite_c = memready;
                pcwrite   = memready;
                if (memready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively from the sign-extended,
                // shifted immediate.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (memready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // The write strobe is held until the memory accepts it. The
                // instruction completes only in the accepting cycle.
                iord       = 1'b1;
                memwrite_c = 1'b1;
                done_c     = memready;
                if (memready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with every control output low.
                state_d = S_FETCH;
            end
        endcase
    end

    // The state register is already FETCH while reset is high. FETCH still
    // follows memready, so the strobes are gated here to stay quiet during reset.
    assign irwrite  = irwrite_c & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign regwrite = regwrite_c & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign done     = done_c & ~reset;
    assign illegal  = illegal_c & ~reset;
    assign state    = state_q;

endmodule
